ota_offset_cal_ctrl: RTL and testbench
======================================

// Module: ota_offset_cal_ctrl
// PURPOSE
//  Sequencer for the digital OTA core. On request it shorts the OTA inputs,
//  runs a successive-approximation search on the offset-trim code using the
//  OTA comparator/output bit, then releases the short and holds the result.
//  Sits between the tile control pins (ui_in/uio) and the OTA analog macro.
// PARAMETERS
//  TRIM_W      6   trim-code width (bits of SAR search)
//  SETTLE_CYC  4   clk cycles waited after each trim change before sampling; >=3
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       async active-low reset
//  ena        in   1       tile enable; low aborts to IDLE
//  start      in   1       1-cycle request to begin calibration
//  cmp_async  in   1       OTA output bit, asynchronous to clk
//  cal_short  out  1       1 = OTA inputs shorted for calibration
//  ota_en     out  1       1 = OTA core enabled
//  trim_code  out  TRIM_W  offset-trim code driven to the OTA
//  busy       out  1       1 while SHORT/BIT states active
//  done       out  1       1-cycle pulse when a calibration completes
// BEHAVIOUR
//  - One clock (clk); reset asynchronous, active-low (rst_n).
//  - Reset: state=IDLE, cal_short=0, ota_en=0, trim_code=0, busy=0, done=0.
//  - cmp_async passes a 2-FF synchroniser (cmp_s); only cmp_s is used.
//  - States: IDLE, SHORT, BIT, HOLD.
//  - IDLE: outputs idle; start&&ena -> SHORT; trim_code cleared to 0,
//    bit index i=TRIM_W-1, cal_short=1, ota_en=1, busy=1.
//  - SHORT: wait SETTLE_CYC cycles -> BIT, setting trim_code[i]=1 (trial).
//  - BIT: lasts SETTLE_CYC+1 cycles: SETTLE_CYC wait, then decide cycle:
//    cmp_s=1 -> clear trim_code[i]; cmp_s=0 -> keep it. If i==0 -> HOLD,
//    else i-=1 and set new trial bit in same edge.
//  - HOLD: cal_short=0, ota_en=1, busy=0, trim_code frozen; done=1 on the
//    first HOLD cycle only. start&&ena in HOLD restarts (-> SHORT).
//  - Latency: start sampled at edge k -> done high after edge
//    k+SETTLE_CYC+TRIM_W*(SETTLE_CYC+1)+1 (35 cycles at defaults).
//  - start while busy: ignored. start with ena=0: ignored.
//  - ena low in any state: next edge -> IDLE, cal_short=0, ota_en=0,
//    busy=0, no done; trim_code retains last value (partial if aborted).
//  - Reset mid-calibration: immediate return to reset values.
//  - done and start same cycle in HOLD: done pulses, restart accepted.
//  - Settle timer: ceil(log2(SETTLE_CYC+1))-bit down-counter, reloaded on
//    every state entry and every trial-bit change; no wrap.
// STRUCTURE
//  - Package ota_ctrl_pkg: state enum (IDLE/SHORT/BIT/HOLD), default
//    TRIM_W and SETTLE_CYC constants.
//  - Sub-module ota_sync2: 2-FF synchroniser, async active-low reset to 0.
//  - FSM, settle counter, SAR register in this module.
// TESTING
//  1 Reset: rst_n=0 mid-BIT -> all outputs at reset values same cycle.
//  2 Model cmp=(trim_code>=37), start pulse -> done after 35 cycles,
//    trim_code=36, cal_short 1->0 at done, ota_en stays 1.
//  3 Model cmp=1 always -> trim_code=0; cmp=0 always -> trim_code=63.
//  4 Repeated start pulses while busy -> no restart, single done at cycle 35.
//  5 ena=0 during third BIT -> IDLE next edge, ota_en=0, no done,
//    trim_code holds partial value; later start restarts from 0.
//  6 start in HOLD with model cmp=(trim_code>=10) -> second done, trim=9.

Source files
------------

// File: rtl/ota_ctrl_pkg.sv
// Shared types and default sizing for the OTA offset-calibration sequencer.
package ota_ctrl_pkg;

    localparam int unsigned TRIM_W_DEF     = 6;
    localparam int unsigned SETTLE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_BIT   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/ota_sync2.sv
// Two-flop synchroniser for the asynchronous OTA comparator bit.
module ota_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; both stages clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ota_offset_cal_ctrl.sv
// OTA offset-calibration sequencer: shorts the inputs, runs a SAR search on
// the trim code using the synchronised comparator bit, then holds the result.
module ota_offset_cal_ctrl
    import ota_ctrl_pkg::*;
#(
    parameter int unsigned TRIM_W     = TRIM_W_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              cmp_async,
    output logic              cal_short,
    output logic              ota_en,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

    state_t            state;
    logic [CNT_W-1:0]  timer;
    logic [IDX_W-1:0]  bit_idx;
    logic [TRIM_W-1:0] sar_next_c;
    logic              cmp_s;

    ota_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_async),
        .q     (cmp_s)
    );

    // SAR decision for the current bit and trial of the next lower bit.
    always_comb begin
        sar_next_c = trim_code;
        if (cmp_s) begin
            sar_next_c[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            sar_next_c[bit_idx - IDX_W'(1)] = 1'b1;
        end
    end

    // Sequencer FSM with settle timer, SAR register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            trim_code <= '0;
            cal_short <= 1'b0;
            ota_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!ena) begin
                // Abort: trim_code keeps whatever partial result it had.
                state     <= ST_IDLE;
                cal_short <= 1'b0;
                ota_en    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_HOLD: begin
                        if (start) begin
                            state     <= ST_SHORT;
                            timer     <= CNT_W'(SETTLE_CYC);
                            bit_idx   <= IDX_W'(TRIM_W - 1);
                            trim_code <= '0;
                            cal_short <= 1'b1;
                            ota_en    <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    ST_SHORT: begin
                        if (timer == '0) begin
                            state              <= ST_BIT;
                            timer              <= CNT_W'(SETTLE_CYC);
                            trim_code[bit_idx] <= 1'b1;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                    ST_BIT: begin
                        if (timer == '0) begin
                            trim_code <= sar_next_c;
                            timer     <= CNT_W'(SETTLE_CYC);
                            if (bit_idx == '0) begin
                                state     <= ST_HOLD;
                                cal_short <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx - IDX_W'(1);
                            end
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ota_offset_cal_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed and
// randomised calibration runs against the offset-calibration sequencer.
module tb_ota_offset_cal_ctrl;

    localparam int unsigned TRIM_W = 6;
    localparam int unsigned SETTLE = 4;
    localparam int P = SETTLE + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              start;
    logic              cmp_async;
    logic              cal_short;
    logic              ota_en;
    logic [TRIM_W-1:0] trim_code;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;
    int cmp_mode = 0;   // 0: threshold, 1: always 1, 2: always 0
    int thr      = 37;

    always #5 clk = ~clk;

    ota_offset_cal_ctrl #(.TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .cmp_async (cmp_async),
        .cal_short (cal_short),
        .ota_en    (ota_en),
        .trim_code (trim_code),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic cmp_fn(input logic [TRIM_W-1:0] c, input int mode, input int t);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return (int'(c) >= t);
    endfunction

    // Analog stand-in: comparator reports 1 when the trim code is too high.
    assign cmp_async = cmp_fn(trim_code, cmp_mode, thr);

    // Behavioural model: run phase tracked as edges since the accepted start.
    int                m_state;   // 0 idle, 1 running, 2 hold
    int                m_t;
    logic [TRIM_W-1:0] m_trim;
    logic              m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_t     <= 0;
            m_trim  <= '0;
            m_done  <= 1'b0;
        end else begin : upd
            int                s, t, m;
            logic [TRIM_W-1:0] tr;
            logic              d;
            s = m_state; t = m_t; tr = m_trim; d = 1'b0;
            if (!ena) begin
                s = 0;
            end else if (s != 1) begin
                if (start) begin s = 1; t = 0; tr = '0; end
            end else begin
                t = t + 1;
                if (t % P == 0) begin
                    m = t / P;
                    if (m >= 2 && cmp_fn(tr, cmp_mode, thr)) tr[TRIM_W-(m-1)] = 1'b0;
                    if (m == TRIM_W + 1) begin s = 2; d = 1'b1; end
                    else tr[TRIM_W-m] = 1'b1;
                end
            end
            m_state <= s;
            m_t     <= t;
            m_trim  <= tr;
            m_done  <= d;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin : cmp
            logic [TRIM_W+3:0] act, exp;
            act = {cal_short, ota_en, busy, done, trim_code};
            exp = {m_state == 1, m_state != 0, m_state == 1, m_done, m_trim};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got short/en/busy/done/trim=%b required %b",
                         $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Pulse start for one edge and count edges until done (bounded).
    task automatic run_cal(input int rand_starts, output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            start = (rand_starts != 0 && n < 30) ? 1'($urandom % 2) : 1'b0;
        end
        start = 1'b0;
    endtask

    int n;
    int len;

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_trim", int'(trim_code), 0);
        check("reset_flags", int'({cal_short, ota_en, busy, done}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset mid-BIT takes effect before the next edge.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        check("in_bit_busy", int'(busy), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_rst_trim", int'(trim_code), 0);
        check("async_rst_flags", int'({cal_short, ota_en, busy, done}), 0);
        @(negedge clk) rst_n = 1'b1;

        // Threshold 37: result 36, latency 35.
        cmp_mode = 0; thr = 37;
        run_cal(0, n);
        check("latency_thr37", n, 35);
        check("trim_thr37", int'(trim_code), 36);
        check("short_at_done", int'(cal_short), 0);
        check("ota_en_at_done", int'(ota_en), 1);
        @(negedge clk);

        cmp_mode = 1;
        run_cal(0, n);
        check("trim_cmp1", int'(trim_code), 0);
        cmp_mode = 2;
        run_cal(0, n);
        check("trim_cmp0", int'(trim_code), 63);

        // Start pulses while busy are ignored.
        cmp_mode = 0; thr = 37;
        run_cal(1, n);
        check("latency_busy_starts", n, 35);
        check("trim_busy_starts", int'(trim_code), 36);

        // Abort during the third BIT state: partial trial code retained.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (17) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("abort_ota_en", int'(ota_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_trim", int'(trim_code), 40);
        repeat (40) @(negedge clk);
        check("abort_no_done", int'(done), 0);
        ena = 1'b1;
        run_cal(0, n);
        check("restart_latency", n, 35);
        check("restart_trim", int'(trim_code), 36);

        // Restart in HOLD in the same cycle that done is high.
        thr = 10;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("hold_restart_latency", n, 35);
        check("hold_restart_trim", int'(trim_code), 9);

        // Randomised runs with stray starts, enable drops and resets.
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            cmp_mode = int'($urandom % 3);
            thr = int'($urandom_range(0, 64));
            start = 1'b1;
            @(negedge clk) start = 1'b0;
            len = int'($urandom_range(5, 45));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                start = ($urandom % 8 == 0);
                ena   = !($urandom % 40 == 0);
                rst_n = !($urandom % 97 == 0);
            end
            start = 1'b0; ena = 1'b1; rst_n = 1'b1;
            repeat (40) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
